// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// Control codes match the existing ALU decode.
package alu_arb_pkg;

  typedef enum logic {EMPTY, FULL} arb_state_t;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;
  localparam int CNT_W   = 16;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             id;
  } alu_resp_t;

endpackage

// File: rtl/ALU.sv
// Existing combinational ALU.
// flags = {negative, zero, carry, overflow}; SUB carry means no borrow.
module ALU #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int SH = $clog2(WIDTH);

  logic [WIDTH:0]  sum;
  logic [SH-1:0]   shamt;
  logic            cy;
  logic            ov;
  logic            lts;
  logic            ltu;

  assign shamt = b[SH-1:0];
  assign lts   = $signed(a) < $signed(b);
  assign ltu   = a < b;

  // Operation decode with carry/overflow for add and subtract
  always_comb begin
    sum    = '0;
    cy     = 1'b0;
    ov     = 1'b0;
    result = '0;
    case (ctrl)
      4'd0: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        cy     = sum[WIDTH];
        ov     = (a[WIDTH-1] == b[WIDTH-1]) &&
                 (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        sum    = {1'b0, a} + {1'b0, ~b} +
                 {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        cy     = sum[WIDTH];
        ov     = (a[WIDTH-1] != b[WIDTH-1]) &&
                 (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2:    result = a & b;
      4'd3:    result = a | b;
      4'd4:    result = a ^ b;
      4'd5:    result = a << shamt;
      4'd6:    result = a >> shamt;
      4'd7:    result = $signed(a) >>> shamt;
      4'd8:    result = {{(WIDTH-1){1'b0}}, lts};
      4'd9:    result = {{(WIDTH-1){1'b0}}, ltu};
      default: result = '0;
    endcase
  end

  assign flags = {result[WIDTH-1], result == '0, cy, ov};

endmodule

// File: rtl/rr_arbiter.sv
// Two-way round-robin grant; prio names the requester that wins a tie.
// With no request, gnt is zero and gnt_idx falls back to 0.
module rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_idx
);

  // Preferred requester first, then the other one
  always_comb begin
    gnt     = '0;
    gnt_idx = 1'b0;
    if (req[prio]) begin
      gnt[prio] = 1'b1;
      gnt_idx   = prio;
    end else if (req[~prio]) begin
      gnt[~prio] = 1'b1;
      gnt_idx    = ~prio;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters.
// One-entry response register, round-robin grant, stall counter.
module alu_arbiter #(
  parameter int NUM_REQ = alu_arb_pkg::NUM_REQ,
  parameter int WIDTH   = alu_arb_pkg::WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_op1,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]  req_op2,
  input  logic [NUM_REQ-1:0][3:0]        req_ctrl,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [WIDTH-1:0]               resp_result,
  output logic [3:0]                     resp_flags,
  output logic                           resp_id,
  output logic [15:0]                    busy_cycles
);
  localparam int CW = alu_arb_pkg::CNT_W;

  alu_arb_pkg::arb_state_t state;
  alu_arb_pkg::arb_state_t state_nxt;
  alu_arb_pkg::alu_resp_t  resp_q;

  logic               prio;
  logic               prio_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_idx;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   alu_y;
  logic [3:0]         alu_f;
  logic [CW-1:0]      busy_q;

  rr_arbiter u_arb (
    .req     (req_valid),
    .prio    (prio),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign can_accept = (state == alu_arb_pkg::EMPTY) || resp_ready;
  assign req_ready  = can_accept ? gnt : '0;
  assign accept     = |req_ready;

  // gnt_idx is 0 when idle, so requester 0 drives the ALU then
  ALU #(.WIDTH(WIDTH)) u_alu (
    .a      (req_op1[gnt_idx]),
    .b      (req_op2[gnt_idx]),
    .ctrl   (req_ctrl[gnt_idx]),
    .result (alu_y),
    .flags  (alu_f)
  );

  // Next state and round-robin pointer
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (accept) begin
      state_nxt = alu_arb_pkg::FULL;
      prio_nxt  = ~gnt_idx;
    end else if (state == alu_arb_pkg::FULL && resp_ready) begin
      state_nxt = alu_arb_pkg::EMPTY;
    end
  end

  // State and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= alu_arb_pkg::EMPTY;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Response register loads only on accept, so it holds under stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q <= '0;
    end else if (accept) begin
      resp_q.result <= alu_y;
      resp_q.flags  <= alu_f;
      resp_q.id     <= gnt_idx;
    end
  end

  // Saturating count of stalled response cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else if (state == alu_arb_pkg::FULL && !resp_ready &&
                 busy_q != {CW{1'b1}}) begin
      busy_q <= busy_q + 1'b1;
    end
  end

  assign resp_valid  = (state == alu_arb_pkg::FULL);
  assign resp_result = resp_q.result;
  assign resp_flags  = resp_q.flags;
  assign resp_id     = resp_q.id;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// Directed table, contention/backpressure sequences, random vs. model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_op1;
  logic [1:0][31:0] req_op2;
  logic [1:0][3:0]  req_ctrl;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic [3:0]       resp_flags;
  logic             resp_id;
  logic [15:0]      busy_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_ctrl    (req_ctrl),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_id     (resp_id),
    .busy_cycles (busy_cycles)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  vec_t tbl[10];

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    req_op1[r]   = a;
    req_op2[r]   = b;
    req_ctrl[r]  = c;
    req_valid[r] = 1'b1;
  endtask

  // Reference ALU from arithmetic definitions; flags {N,Z,C,V}
  function automatic void alu_ref(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] c, output logic [31:0] y,
                                  output logic [3:0] f);
    int              ia;
    int              ib;
    longint          sa;
    longint          sb;
    longint          sr;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned ur;
    logic            cy;
    logic            ov;
    ia = a;
    ib = b;
    sa = longint'(ia);
    sb = longint'(ib);
    ua = {32'd0, a};
    ub = {32'd0, b};
    cy = 1'b0;
    ov = 1'b0;
    y  = '0;
    case (c)
      4'd0: begin
        ur = ua + ub; y = ur[31:0]; cy = ur[32];
        sr = sa + sb; ov = (sr > MAXS) || (sr < MINS);
      end
      4'd1: begin
        y = a - b; cy = (ua >= ub);
        sr = sa - sb; ov = (sr > MAXS) || (sr < MINS);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << b[4:0];
      4'd6: y = a >> b[4:0];
      4'd7: begin sr = sa >>> b[4:0]; y = sr[31:0]; end
      4'd8: y = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: y = (ua < ub) ? 32'd1 : 32'd0;
      default: y = '0;
    endcase
    f = {y[31], y == 32'd0, cy, ov};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] my;
    logic [3:0]  mf;
    logic [31:0] m_res;
    logic [3:0]  m_flags;
    logic        m_id;
    bit          m_full;
    int          m_busy;
    int          m_pref;
    int          g;
    bit          can;
    bit          pend[2];
    logic [1:0]  exp_rdy;

    tbl[0] = '{1'b0, 32'h5, 32'h3, ALU_ADD, 32'h8, 4'b0000};
    tbl[1] = '{1'b1, 32'h3, 32'h5, ALU_SUB, 32'hFFFF_FFFE, 4'b1000};
    tbl[2] = '{1'b0, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h8000_0000, 4'b1001};
    tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 32'h0, 4'b0110};
    tbl[4] = '{1'b0, 32'h9, 32'h9, ALU_SUB, 32'h0, 4'b0110};
    tbl[5] = '{1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, ALU_AND,
               32'h00F0_1200, 4'b0000};
    tbl[6] = '{1'b0, 32'h8000_0000, 32'h4, ALU_SRA, 32'hF800_0000, 4'b1000};
    tbl[7] = '{1'b1, 32'hFFFF_FFFF, 32'h1, ALU_SLT, 32'h1, 4'b0000};
    tbl[8] = '{1'b0, 32'hFFFF_FFFF, 32'h1, ALU_SLTU, 32'h0, 4'b0100};
    tbl[9] = '{1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, ALU_XOR,
               32'hF0F0_0F0F, 4'b1000};

    reset      = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_ctrl   = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_flags", 32'(resp_flags), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy_cycles), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    step();

    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = '0;
      set_req(int'(tbl[i].id), tbl[i].a, tbl[i].b, tbl[i].c);
      @(negedge clk);
      chk("tbl_ready", 32'(req_ready), tbl[i].id ? 32'd2 : 32'd1);
      step();
      req_valid = '0;
      chk("tbl_valid", 32'(resp_valid), 32'd1);
      chk("tbl_result", resp_result, tbl[i].y);
      chk("tbl_flags", 32'(resp_flags), 32'(tbl[i].f));
      chk("tbl_id", 32'(resp_id), 32'(tbl[i].id));
    end

    set_req(0, 32'd100, 32'd23, ALU_ADD);
    set_req(1, 32'd50, 32'd8, ALU_SUB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready", 32'(req_ready), (i % 2) ? 32'd2 : 32'd1);
      step();
      chk("cont_id", 32'(resp_id), 32'(i % 2));
      chk("cont_result", resp_result, (i % 2) ? 32'd42 : 32'd123);
    end

    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
      step();
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_result", resp_result, 32'd42);
      chk("bp_busy", 32'(busy_cycles), 32'(i + 1));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    chk("bp_release_id", 32'(resp_id), 32'd0);
    chk("bp_release_result", resp_result, 32'd123);
    chk("bp_release_busy", 32'(busy_cycles), 32'd3);
    req_valid = '0;
    step();
    chk("drain_valid", 32'(resp_valid), 32'd0);

    set_req(1, 32'd1, 32'd2, ALU_ADD);
    step();
    req_valid = '0;
    chk("idle_r1_id", 32'(resp_id), 32'd1);
    step();
    step();
    set_req(0, 32'd10, 32'd20, ALU_ADD);
    set_req(1, 32'd30, 32'd40, ALU_ADD);
    @(negedge clk);
    chk("idle_prio_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    chk("idle_prio_id", 32'(resp_id), 32'd0);
    chk("idle_prio_result", resp_result, 32'd30);

    resp_ready = 1'b0;
    req_valid  = 2'b11;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(resp_valid), 32'd0);
    chk("async_rst_result", resp_result, 32'd0);
    resp_ready = 1'b1;
    step();
    chk("rst_cycle_accept_lost", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    step();
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy_cycles), 32'd0);

    m_full  = 1'b0;
    m_busy  = 0;
    m_pref  = 0;
    m_res   = '0;
    m_flags = '0;
    m_id    = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int k = 0; k < 500; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(pend[r] && $urandom_range(3) != 0)) begin
          req_valid[r] = ($urandom_range(2) != 0);
          req_op1[r]   = $urandom;
          req_op2[r]   = $urandom;
          req_ctrl[r]  = 4'($urandom_range(15));
        end
      end
      resp_ready = 1'($urandom_range(1));
      @(negedge clk);
      g = -1;
      if (req_valid[m_pref]) g = m_pref;
      else if (req_valid[1 - m_pref]) g = 1 - m_pref;
      can = !m_full || resp_ready;
      exp_rdy = (g >= 0 && can) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("rand_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_full && !resp_ready && m_busy < 65535) m_busy++;
      if (g >= 0 && can) begin
        alu_ref(req_op1[g], req_op2[g], req_ctrl[g], my, mf);
        m_res   = my;
        m_flags = mf;
        m_id    = (g == 1);
        m_full  = 1'b1;
        m_pref  = 1 - g;
      end else if (resp_ready) begin
        m_full = 1'b0;
      end
      for (int r = 0; r < 2; r++)
        pend[r] = req_valid[r] && !(g == r && can);
      step();
      chk("rand_valid", 32'(resp_valid), 32'(m_full));
      if (m_full) begin
        chk("rand_result", resp_result, m_res);
        chk("rand_flags", 32'(resp_flags), 32'(m_flags));
        chk("rand_id", 32'(resp_id), 32'(m_id));
      end
      chk("rand_busy", 32'(busy_cycles), 32'(m_busy));
    end

    req_valid  = '0;
    resp_ready = 1'b1;
    step();
    set_req(0, 32'h1234, 32'h1, ALU_ADD);
    step();
    req_valid  = '0;
    resp_ready = 1'b0;
    chk("sat_start_valid", 32'(resp_valid), 32'd1);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_busy", 32'(busy_cycles), 32'hFFFF);
    chk("sat_valid", 32'(resp_valid), 32'd1);
    chk("sat_result", resp_result, 32'h1235);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single existing `ALU` instance between two requesters, e.g. an integer-execute path and an address-generation path, using valid/ready handshakes on both sides. Each cycle the block grants one pending request by round-robin, drives that requester's operands and control into the `ALU`, and captures result, flags and requester ID in a one-entry output register. The output register holds its contents under downstream backpressure. The block sits between the issue logic and the `ALU`, and it is the only driver of the `ALU` inputs.

## Interface
- `NUM_REQ`, 2: number of requesters. Fixed at 2 in this revision.
- `WIDTH`, 32: operand and result width.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  [NUM_REQ-1:0]: request i is pending.
- `req_ready`  out  [NUM_REQ-1:0]: request i is accepted this cycle.
- `req_op1`, `req_op2`  in  [NUM_REQ-1:0][WIDTH-1:0]: operands per requester.
- `req_ctrl`  in  [NUM_REQ-1:0][3:0]: ALU control code per requester. Passed to the `ALU` unchanged.
- `resp_valid`  out  1: the response register holds a result.
- `resp_ready`  in  1: the consumer takes the response this cycle.
- `resp_result`  out  [WIDTH-1:0]: registered `ALU` result.
- `resp_flags`  out  [3:0]: registered `ALU` flags. Same bit order as the `ALU`.
- `resp_id`  out  1: index of the requester that owns the response.
- `busy_cycles`  out  [15:0]: count of cycles with `resp_valid`=1 and `resp_ready`=0. Saturates at 16'hFFFF.

## Operation
- States are `EMPTY` (response register empty) and `FULL` (response register holds a result).
- `can_accept` = (state==`EMPTY`) or (`resp_ready`=1).
- Arbitration:
  - Round-robin pointer `prio` selects which requester wins a tie.
  - Grant g = `prio` if `req_valid[prio]`, else the other requester if it is valid, else none.
  - `req_ready[g]` = `can_accept`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, `prio`, state and `resp_ready`.
- Accept: `req_valid[g]` & `req_ready[g]`.
- ALU drive:
  - `ALU` inputs are driven from the granted requester.
  - With no grant, requester 0 drives the `ALU`; its outputs are unused.
- On accept:
  - Register `result`, `flags` and g into `resp_*`.
  - State goes to `FULL`.
  - `prio` becomes ~g.
- Without accept:
  - If `resp_ready` is 1 in `FULL`, state goes to `EMPTY`.
  - `prio` is unchanged.
- Simultaneous drain and accept in `FULL` with `resp_ready`=1: the new response replaces the old one and state stays `FULL`. Throughput is one operation per cycle.
- `resp_*` data is stable while `resp_valid`=1 and `resp_ready`=0.
- `busy_cycles` increments once per stalled cycle and saturates.
- Reset values (asynchronous):
  - State `EMPTY`, `prio`=0, `resp_valid`=0.
  - `resp_result`=0, `resp_flags`=0, `resp_id`=0, `busy_cycles`=0.
- Reset mid-operation: any held response is discarded. An accept in the reset cycle is lost.

## Timing
- Latency: a request accepted at edge N appears as `resp_valid`=1 after edge N. The consumer can take it at edge N+1.
- The `ALU` is combinational and is evaluated in the accept cycle. The critical path is requester mux → `ALU` → response register.
- Requesters must hold operands and control stable while `req_valid`=1 and `req_ready`=0.
- A requester may drop `req_valid` before being accepted. The block does not require sticky requests.
- Under continuous contention with `resp_ready`=1, grants alternate 0,1,0,1. The maximum wait is 1 cycle.

## Structure
- Package `alu_arb_pkg`:
  - `typedef enum logic {EMPTY, FULL} arb_state_t`.
  - `localparam NUM_REQ=2`, `WIDTH=32`, `CNT_W=16`.
  - `typedef struct packed {logic [WIDTH-1:0] result; logic [3:0] flags; logic id;} alu_resp_t`.
- Sub-module `rr_arbiter`:
  - Inputs: `req` [NUM_REQ-1:0], `prio`.
  - Outputs: `gnt` one-hot, `gnt_idx`.
  - Purely combinational.
- Instantiates the existing `ALU` unchanged.

## Test plan
- Reset release, no requests:
  - All outputs are 0 and `req_ready`=2'b00.
  - Assert `reset` while `FULL` → `resp_valid` drops immediately, without waiting for a clock edge.
- Single request:
  - Stimulus: req0 only, op1=32'h0000_0005, op2=32'h0000_0003, ctrl=ADD code, `resp_ready`=1.
  - Response: `req_ready`=2'b01, then next cycle `resp_valid`=1, `resp_result`=32'h0000_0008, `resp_id`=0, flags equal to the standalone `ALU` flags.
- Contention:
  - Stimulus: both requesters valid for 4 cycles with `resp_ready`=1.
  - Response: `resp_id` sequence 0,1,0,1, one response per cycle, each result matching its requester's operands.
- Backpressure:
  - Stimulus: `resp_ready`=0 for 3 cycles after the first response.
  - Response: `req_ready`=2'b00, `resp_*` stable, `busy_cycles`=3.
  - Raising `resp_ready` drains the response and accepts the next request in the same cycle.
- Priority after idle:
  - Stimulus: grant req1, idle 2 cycles, then both requesters valid.
  - Response: req0 is granted first, because `prio`=0 after the req1 grant.
- Saturation:
  - Stimulus: force a 70 000-cycle stall.
  - Response: `busy_cycles`=16'hFFFF and the counter does not wrap.
